rom_burst_reader: RTL and testbench
===================================

# rom_burst_reader

Parametrised multi-table lookup ROM with a registered, burst-capable streaming read port. Given a start address and a burst length, it walks consecutive addresses, wrapping modulo depth, and emits one word from every table in parallel per beat on a valid/ready output handshake. It replaces the combinational case-ROM with a pipelined source for downstream datapath blocks, with backpressure and chip-enable pause.

## Interface
Parameters:
- DATA_W, 8, width of each table word.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- NUM_TABLES, 4, tables read in parallel (legal 1..4).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  chip enable; 0 freezes all state.
- start  input  1  burst request; sampled only in IDLE with ce=1.
- start_addr  input  ADDR_W  first address of burst.
- burst_len  input  ADDR_W  beats minus one (0 → 1 beat, all-ones → depth beats).
- data_o  output  NUM_TABLES*DATA_W  table t at data_o[t*DATA_W +: DATA_W].
- valid_o  output  1  data_o holds a beat.
- ready_i  input  1  consumer accepts the beat.
- last_o  output  1  current beat is the final one of the burst.
- busy_o  output  1  burst in progress.
- par_o  output  NUM_TABLES  even parity per table word (see Configuration).

## Operation
- Table contents, for address a zero-extended to DATA_W and results mod 2**DATA_W:
  - t0 = a
  - t1 = a*a
  - t2 = ~a
  - t3 = 3*a + 1
- FSM states: IDLE, STREAM.
  - IDLE → STREAM on start & ce. Latches addr = start_addr and remaining = burst_len. Loads data_o with the start_addr words. Sets valid_o; sets last_o = (burst_len == 0).
  - STREAM: a transfer occurs when valid_o & ready_i & ce.
    - On a non-final transfer: addr increments mod depth, remaining decrements, data_o reloads, last_o = (new remaining == 0).
    - On the final transfer (last_o=1): → IDLE; valid_o, last_o, busy_o clear.
- Backpressure: with ready_i=0, data_o, last_o and par_o hold stable and valid_o stays 1.
- ce=0: every register holds. valid_o is gated to 0 combinationally, so no transfer can occur. When ce returns, the same beat is presented again.
- start while busy_o=1 is ignored; there is no queueing.
- Reset (any time, including mid-burst): state IDLE; data_o=0, valid_o=0, last_o=0, busy_o=0, par_o=0, internal addr/remaining=0.

## Timing
- Latency: start accepted at edge N → valid_o=1 with the first beat after edge N, in the same cycle busy_o rises.
- Throughput: one beat per cycle while ready_i=1 and ce=1.
- After the final transfer at edge K, busy_o=0 after K. The earliest new start is sampled at edge K+1, giving a one-cycle bubble between bursts.
- Address wrap: addr 2**ADDR_W−1 is followed by addr 0 within the same burst.

## Configuration
- ROM_PARITY_EN defined: par_o[t] = XOR of the bits of table t's word, registered alongside data_o, with the same timing and hold behaviour.
- ROM_PARITY_EN undefined: par_o tied to 0 and no parity logic is built.

## Structure
- Package rom_burst_pkg holds:
  - the FSM state enum;
  - the table-index constants T_ID, T_SQR, T_INV, T_LIN;
  - a function rom_word(table, addr) implementing the table formulas.
- One sub-module, rom_table_bank. It is combinational, takes addr and produces all NUM_TABLES words (and parity when enabled). The top holds the FSM, counters and output registers.

## Test plan
All scenarios use DATA_W=8, ADDR_W=3, NUM_TABLES=4.
- Reset, then idle → data_o=0, valid_o=0, busy_o=0, last_o=0. Assert rst mid-burst → same values immediately, with no clock edge needed.
- start_addr=0, burst_len=7, ready_i=1 → 8 consecutive beats:
  - t0 = 00..07
  - t1 = 00,01,04,09,10,19,24,31 (hex)
  - t2 = FF..F8
  - t3 = 01,04,07,0A,0D,10,13,16
  - last_o only on beat 8; busy_o falls the next cycle.
- start_addr=6, burst_len=3 → addresses 6,7,0,1 (t0 = 06,07,00,01), last_o on the fourth beat.
- Drop ready_i for 3 cycles on beat 2 of a burst from addr 0 → data_o holds t0=01 and valid_o=1 for those cycles; the stream resumes with 02 and no beat is lost or duplicated.
- Drop ce for 2 cycles mid-burst → valid_o=0 during the gap, and the same beat is re-presented afterwards. Pulse start during STREAM → ignored, burst unchanged.
- With ROM_PARITY_EN, start_addr=1, burst_len=0 → data_o words 01,01,FE,04, par_o=4'b1111, last_o=1 on the single beat. Without the macro, par_o=0.

Source files
------------

// File: rtl/rom_burst_pkg.sv
// Shared types and table definitions for the burst-reading lookup ROM.
package rom_burst_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int T_ID  = 0;
  localparam int T_SQR = 1;
  localparam int T_INV = 2;
  localparam int T_LIN = 3;

  // Word of table `tbl` at address `a`. Computed 32 bits wide; callers
  // truncate to DATA_W, which yields the result mod 2**DATA_W.
  function automatic logic [31:0] rom_word(input int tbl, input logic [31:0] a);
    logic [31:0] w;
    case (tbl)
      T_ID:    w = a;
      T_SQR:   w = a * a;
      T_INV:   w = ~a;
      default: w = 32'd3 * a + 32'd1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rom_burst_reader_bank.sv
// rom_table_bank: combinational read of every table at one address.
// With ROM_PARITY_EN defined it also produces even parity per word.
module rom_table_bank
  import rom_burst_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int NUM_TABLES = 4
) (
  input  logic [ADDR_W-1:0]            addr,
`ifdef ROM_PARITY_EN
  output logic [NUM_TABLES-1:0]        par,
`endif
  output logic [NUM_TABLES*DATA_W-1:0] words
);

  for (genvar t = 0; t < NUM_TABLES; t++) begin : g_tbl
    assign words[t*DATA_W +: DATA_W] = DATA_W'(rom_word(t, 32'(addr)));
`ifdef ROM_PARITY_EN
    assign par[t] = ^words[t*DATA_W +: DATA_W];
`endif
  end

endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: walks a burst of consecutive ROM addresses (mod depth)
// and streams one word per table per beat on a valid/ready port.
// ce=0 freezes all state and masks valid_o.
// Optional feature macro: ROM_PARITY_EN (registered per-table parity on par_o).
module rom_burst_reader
  import rom_burst_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int NUM_TABLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            start_addr,
  input  logic [ADDR_W-1:0]            burst_len,
  output logic [NUM_TABLES*DATA_W-1:0] data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o,
  output logic                         busy_o,
  output logic [NUM_TABLES-1:0]        par_o
);

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [ADDR_W-1:0]           rem_q, rem_d;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic                        load;
  logic [ADDR_W-1:0]           bank_addr;
  logic [NUM_TABLES*DATA_W-1:0] bank_words;
  logic [NUM_TABLES*DATA_W-1:0] data_q;

`ifdef ROM_PARITY_EN
  logic [NUM_TABLES-1:0]       bank_par;
  logic [NUM_TABLES-1:0]       par_q;
`endif

  // The bank always looks up the address that would be loaded next.
  rom_table_bank #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_TABLES(NUM_TABLES)
  ) u_bank (
    .addr (bank_addr),
`ifdef ROM_PARITY_EN
    .par  (bank_par),
`endif
    .words(bank_words)
  );

  // Next-state and output-register update decisions.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    valid_d   = valid_q;
    last_d    = last_q;
    load      = 1'b0;
    bank_addr = addr_q + 1'b1;
    case (state_q)
      IDLE: begin
        bank_addr = start_addr;
        if (start) begin
          state_d = STREAM;
          addr_d  = start_addr;
          rem_d   = burst_len;
          load    = 1'b1;
          valid_d = 1'b1;
          last_d  = (burst_len == '0);
        end
      end
      STREAM: begin
        if (valid_q && ready_i) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            load   = 1'b1;
            last_d = (rem_q == ADDR_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; ce=0 holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (ce) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      if (load) data_q <= bank_words;
    end
  end

`ifdef ROM_PARITY_EN
  // Parity registered alongside data_q so it holds and advances with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            par_q <= '0;
    else if (ce && load) par_q <= bank_par;
  end
  assign par_o = par_q;
`else
  assign par_o = '0;
`endif

  assign data_o  = data_q;
  assign valid_o = valid_q & ce;
  assign last_o  = last_q;
  assign busy_o  = (state_q == STREAM);

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader (DATA_W=8, ADDR_W=3, NUM_TABLES=4).
// A queue-of-addresses reference model predicts every output each cycle.
module tb_rom_burst_reader;

  logic        clk = 1'b0;
  logic        rst, ce, start, ready_i;
  logic [2:0]  start_addr, burst_len;
  logic [31:0] data_o;
  logic        valid_o, last_o, busy_o;
  logic [3:0]  par_o;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_busy;
  int          m_q[$];
  logic [31:0] m_data;
  logic [3:0]  m_par;
  logic [31:0] beat_log[$];

  logic [7:0] t1_tab [8] = '{8'h00, 8'h01, 8'h04, 8'h09, 8'h10, 8'h19, 8'h24, 8'h31};
  logic [7:0] t3_tab [8] = '{8'h01, 8'h04, 8'h07, 8'h0A, 8'h0D, 8'h10, 8'h13, 8'h16};
  logic [7:0] wrap_tab [4] = '{8'h06, 8'h07, 8'h00, 8'h01};

  rom_burst_reader #(.DATA_W(8), .ADDR_W(3), .NUM_TABLES(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .start_addr(start_addr),
    .burst_len(burst_len), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o), .busy_o(busy_o), .par_o(par_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int a);
    int t0, t1, t2, t3;
    t0 = a % 256;
    t1 = (a * a) % 256;
    t2 = 255 - t0;
    t3 = (3 * a + 1) % 256;
    return {t3[7:0], t2[7:0], t1[7:0], t0[7:0]};
  endfunction

  function automatic logic [3:0] exp_par(input logic [31:0] w);
`ifdef ROM_PARITY_EN
    return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
`else
    return (w == 32'hFFFF_FFFF) ? 4'h0 : 4'h0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_q.delete();
    m_data = '0;
    m_par  = '0;
  endtask

  // One clock cycle: apply inputs, check outputs, advance the model by the edge.
  task automatic cyc(input logic s, input logic [2:0] sa, input logic [2:0] bl,
                     input logic rdy, input logic c);
    @(negedge clk);
    start = s; start_addr = sa; burst_len = bl; ready_i = rdy; ce = c;
    #1;
    chk("valid", valid_o, m_busy & c);
    chk("busy",  busy_o, m_busy);
    chk("last",  last_o, m_busy && (m_q.size() == 1));
    chk("data",  data_o, m_data);
    chk("par",   par_o,  m_par);
    if (c) begin
      if (!m_busy) begin
        if (s) begin
          for (int i = 0; i <= int'(bl); i++) m_q.push_back((int'(sa) + i) % 8);
          m_busy = 1;
          m_data = exp_word(m_q[0]);
          m_par  = exp_par(m_data);
        end
      end else if (rdy) begin
        beat_log.push_back(m_data);
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_busy = 0;
        else begin
          m_data = exp_word(m_q[0]);
          m_par  = exp_par(m_data);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; start = 1'b0; ready_i = 1'b1;
    start_addr = '0; burst_len = '0;
    model_reset();
    #12;
    chk("rst_data", data_o, 32'h0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_last", last_o, 1'b0);
    @(negedge clk); rst = 1'b0;
    repeat (2) cyc(0, 0, 0, 1, 1);

    // Full burst from 0, checked against tabulated values
    beat_log.delete();
    cyc(1, 0, 7, 1, 1);
    repeat (9) cyc(0, 0, 0, 1, 1);
    chk("b0_len", beat_log.size(), 8);
    for (int i = 0; i < 8 && i < beat_log.size(); i++) begin
      chk("b0_t0", beat_log[i][7:0], i);
      chk("b0_t1", beat_log[i][15:8], t1_tab[i]);
      chk("b0_t2", beat_log[i][23:16], 8'hFF - 8'(i));
      chk("b0_t3", beat_log[i][31:24], t3_tab[i]);
    end

    // Address wrap
    beat_log.delete();
    cyc(1, 6, 3, 1, 1);
    repeat (5) cyc(0, 0, 0, 1, 1);
    chk("wrap_len", beat_log.size(), 4);
    for (int i = 0; i < 4 && i < beat_log.size(); i++)
      chk("wrap_t0", beat_log[i][7:0], wrap_tab[i]);

    // Backpressure on beat 2
    beat_log.delete();
    cyc(1, 0, 7, 1, 1);
    cyc(0, 0, 0, 1, 1);
    repeat (3) begin
      cyc(0, 0, 0, 0, 1);
      chk("bp_hold", data_o[7:0], 8'h01);
      chk("bp_valid", valid_o, 1'b1);
    end
    repeat (8) cyc(0, 0, 0, 1, 1);
    chk("bp_len", beat_log.size(), 8);
    for (int i = 0; i < 8 && i < beat_log.size(); i++) chk("bp_t0", beat_log[i][7:0], i);

    // ce gap and start pulse while streaming
    beat_log.delete();
    cyc(1, 2, 5, 1, 1);
    cyc(0, 0, 0, 1, 1);
    repeat (2) begin
      cyc(1, 5, 1, 1, 0);
      chk("ce_valid", valid_o, 1'b0);
    end
    cyc(1, 5, 1, 1, 1);
    repeat (6) cyc(0, 0, 0, 1, 1);
    chk("ce_len", beat_log.size(), 6);
    for (int i = 0; i < 6 && i < beat_log.size(); i++) chk("ce_t0", beat_log[i][7:0], 2 + i);

    // Single-beat burst with parity
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("one_data", data_o, 32'h04FE_0101);
    chk("one_last", last_o, 1'b1);
`ifdef ROM_PARITY_EN
    chk("one_par", par_o, 4'b1111);
`else
    chk("one_par", par_o, 4'b0000);
`endif
    repeat (2) cyc(0, 0, 0, 1, 1);

    // Randomized traffic
    repeat (400)
      cyc(($urandom_range(3) == 0), 3'($urandom), 3'($urandom),
          ($urandom_range(3) != 0), ($urandom_range(7) != 0));

    // Asynchronous reset mid-burst
    cyc(1, 3, 7, 1, 1);
    repeat (2) cyc(0, 0, 0, 1, 1);
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("arst_data", data_o, 32'h0);
    chk("arst_valid", valid_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_last", last_o, 1'b0);
    chk("arst_par", par_o, 4'h0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    repeat (3) cyc(0, 0, 0, 1, 1);
    cyc(1, 7, 2, 1, 1);
    repeat (4) cyc(0, 0, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
